// File: rtl/wr_fram_pack_pkg.sv
// wr_fram_pack_pkg: FSM encoding and line geometry shared by the write and DDR-side buffer ports
package wr_fram_pack_pkg;
  typedef enum logic [1:0] {IDLE, WAIT_LINE, PACK, DROP} state_t;
  localparam int LINE_WORDS = 512;
  localparam int LINE_BITS = 4;
endpackage

// File: rtl/wr_fram_pack_credit.sv
// wr_fram_credit: saturating up/down line-credit counter with a zero flag
module wr_fram_credit #(
  parameter int MAX = 16
) (
  input  logic       wr_clk,
  input  logic       wr_rst,
  input  logic [1:0] inc,
  input  logic       dec,
  output logic       zero
);
  localparam int W = $clog2(MAX + 1);
  logic [W-1:0] cnt;
  logic [W+1:0] nxt;
  assign nxt = (W+2)'(cnt) + (W+2)'(inc) - (W+2)'(dec);
  assign zero = cnt == '0;
  always_ff @(posedge wr_clk or posedge wr_rst)
    if (wr_rst) cnt <= W'(MAX);
    else cnt <= nxt > (W+2)'(MAX) ? W'(MAX) : nxt[W-1:0];
endmodule

// File: rtl/wr_fram_pack.sv
// wr_fram_pack: packs 16-bit pixels into 32-bit words and writes whole lines into a circular
// 16-line buffer, dropping lines when the reader holds no free line credit
module wr_fram_pack
  import wr_fram_pack_pkg::*;
#(
  parameter int PIX_WIDTH     = 16,
  parameter int WR_DATA_WIDTH = 2 * PIX_WIDTH,
  parameter int WR_ADDR_WIDTH = 13,
  parameter int H_PIX         = 2 * LINE_WORDS,
  parameter int NUM_LINES     = 2 ** LINE_BITS
) (
  input  logic                         wr_clk,
  input  logic                         wr_rst,
  input  logic                         vs_in,
  input  logic                         de_in,
  input  logic [PIX_WIDTH-1:0]         pix_in,
  input  logic                         line_free,
  output logic [WR_DATA_WIDTH-1:0]     wr_data,
  output logic [WR_ADDR_WIDTH-1:0]     wr_addr,
  output logic                         wr_en,
  output logic                         line_done,
  output logic [$clog2(NUM_LINES)-1:0] line_idx,
  output logic                         frame_start,
  output logic                         ovf,
  output logic                         len_err
);
  localparam int LB = $clog2(NUM_LINES);
  localparam int WB = WR_ADDR_WIDTH - LB;
  localparam logic [WB:0] LW = (WB+1)'(H_PIX / 2);
  state_t state, state_n;
  logic vs_d, de_d, vs_rise, de_rise, de_fall;
  logic start, abort, finish, cr_zero, odd, done_pend;
  logic [LB-1:0] line_ptr;
  logic [WB:0] word_cnt;
  logic [PIX_WIDTH-1:0] lo;
  assign vs_rise = vs_in & ~vs_d;
  assign de_rise = de_in & ~de_d;
  assign de_fall = ~de_in & de_d;
  assign start = state == WAIT_LINE && de_rise && !vs_rise && !cr_zero;
  assign abort = state == PACK && vs_rise;
  assign finish = state == PACK && de_fall && !vs_rise;
  wr_fram_credit #(.MAX(NUM_LINES)) u_credit (
    .wr_clk(wr_clk),
    .wr_rst(wr_rst),
    .inc({line_free & abort, line_free ^ abort}),
    .dec(start),
    .zero(cr_zero)
  );
  always_ff @(posedge wr_clk or posedge wr_rst)
    if (wr_rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = vs_rise ? WAIT_LINE
            : (state == WAIT_LINE && de_rise) ? (cr_zero ? DROP : PACK)
            : ((state == PACK || state == DROP) && de_fall) ? WAIT_LINE
            : state;
  end
  always_ff @(posedge wr_clk or posedge wr_rst)
    if (wr_rst) begin
      vs_d <= 1'b0;
      de_d <= 1'b0;
      wr_data <= '0;
      wr_addr <= '0;
      wr_en <= 1'b0;
      line_done <= 1'b0;
      line_idx <= '0;
      frame_start <= 1'b0;
      ovf <= 1'b0;
      len_err <= 1'b0;
      line_ptr <= '0;
      word_cnt <= '0;
      lo <= '0;
      odd <= 1'b0;
      done_pend <= 1'b0;
    end else begin
      vs_d <= vs_in;
      de_d <= de_in;
      wr_en <= 1'b0;
      line_done <= 1'b0;
      done_pend <= 1'b0;
      frame_start <= vs_rise;
      if (vs_rise) begin
        ovf <= 1'b0;
        len_err <= 1'b0;
      end
      if (state == WAIT_LINE && de_rise && !vs_rise && cr_zero) ovf <= 1'b1;
      if (start) begin
        lo <= pix_in;
        odd <= 1'b1;
        word_cnt <= '0;
      end else if (state == PACK && de_in && !vs_rise) begin
        if (word_cnt == LW) len_err <= 1'b1;
        else if (!odd) begin
          lo <= pix_in;
          odd <= 1'b1;
        end else begin
          wr_data <= {pix_in, lo};
          wr_addr <= {line_ptr, word_cnt[WB-1:0]};
          wr_en <= 1'b1;
          word_cnt <= word_cnt + 1'b1;
          odd <= 1'b0;
        end
      end
      // a trailing half-word is padded and delays line_done by one cycle
      if (finish) begin
        if (word_cnt != LW) len_err <= 1'b1;
        if (odd) begin
          wr_data <= {{PIX_WIDTH{1'b0}}, lo};
          wr_addr <= {line_ptr, word_cnt[WB-1:0]};
          wr_en <= 1'b1;
          done_pend <= 1'b1;
        end else begin
          line_done <= 1'b1;
          line_idx <= line_ptr;
        end
        line_ptr <= line_ptr + 1'b1;
      end
      if (done_pend) begin
        line_done <= 1'b1;
        line_idx <= line_ptr - 1'b1;
      end
    end
endmodule

// File: tb/tb_wr_fram_pack.sv
// tb_wr_fram_pack: scoreboard bench for wr_fram_pack; expected writes and line indices are queued as pixels are driven
module tb_wr_fram_pack;
  typedef struct {logic [12:0] a; logic [31:0] d;} wr_t;
  logic wr_clk = 1'b0, wr_rst = 1'b1, vs_in = 1'b0, de_in = 1'b0, line_free = 1'b0;
  logic [15:0] pix_in = '0;
  logic [31:0] wr_data;
  logic [12:0] wr_addr, last_addr;
  logic wr_en, line_done, frame_start, ovf, len_err;
  logic [3:0] line_idx;
  wr_t wq[$];
  int dq[$];
  int n_tests = 0, n_fail = 0, n_fs = 0, exp_fs = 0;
  int ptr = 0, cred = 16;
  bit armed = 0, ovf_m = 0, lerr_m = 0, wrap_seen = 0;
  wr_fram_pack dut (
    .wr_clk(wr_clk), .wr_rst(wr_rst), .vs_in(vs_in), .de_in(de_in), .pix_in(pix_in),
    .line_free(line_free), .wr_data(wr_data), .wr_addr(wr_addr), .wr_en(wr_en),
    .line_done(line_done), .line_idx(line_idx), .frame_start(frame_start), .ovf(ovf), .len_err(len_err)
  );
  always #5 wr_clk = ~wr_clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  always @(negedge wr_clk) if (!wr_rst) begin
    if (wr_en) begin
      if (wq.size() == 0) chk("unexpected_wr", 1, 0);
      else begin
        wr_t e;
        e = wq.pop_front();
        chk("wr_addr", 32'(wr_addr), 32'(e.a));
        chk("wr_data", wr_data, e.d);
      end
      if (wr_addr == 13'd0 && last_addr == 13'd8191) wrap_seen = 1;
      last_addr = wr_addr;
    end
    if (line_done) begin
      if (dq.size() == 0) chk("unexpected_line_done", 1, 0);
      else chk("line_idx", 32'(line_idx), 32'(dq.pop_front()));
    end
    if (frame_start) n_fs++;
  end
  task automatic free_pulse();
    @(negedge wr_clk) line_free = 1'b1;
    @(negedge wr_clk) line_free = 1'b0;
    if (cred < 16) cred++;
  endtask
  task automatic vs_pulse();
    @(negedge wr_clk) vs_in = 1'b1;
    @(negedge wr_clk) vs_in = 1'b0;
    armed = 1; ovf_m = 0; lerr_m = 0; exp_fs++;
    @(negedge wr_clk);
    chk("fs_count", n_fs, exp_fs);
    chk("ovf_clr", 32'(ovf), 0);
    chk("len_err_clr", 32'(len_err), 0);
  endtask
  task automatic send_line(input int n, input int base, input bit abort, input bit free);
    bit w;
    w = armed && cred > 0;
    if (w) cred--;
    if (armed && !w) ovf_m = 1;
    for (int i = 0; i < n; i++) begin
      @(negedge wr_clk);
      de_in = 1'b1;
      pix_in = 16'(base + i);
      if (w && i % 2 == 1 && i < 1024)
        wq.push_back('{13'(ptr * 512 + i / 2), {16'(base + i), 16'(base + i - 1)}});
    end
    @(negedge wr_clk);
    de_in = 1'b0;
    if (abort) begin
      vs_in = 1'b1;
      exp_fs++; ovf_m = 0; lerr_m = 0;
      if (w) cred++;
    end else if (w) begin
      if (n % 2 == 1 && n <= 1024) wq.push_back('{13'(ptr * 512 + n / 2), {16'h0, 16'(base + n - 1)}});
      if (n != 1024) lerr_m = 1;
      dq.push_back(ptr);
      ptr = (ptr + 1) % 16;
    end
    repeat (3) @(negedge wr_clk) vs_in = 1'b0;
    chk("wq_drained", wq.size(), 0);
    chk("dq_drained", dq.size(), 0);
    chk("ovf", 32'(ovf), 32'(ovf_m));
    chk("len_err", 32'(len_err), 32'(lerr_m));
    if (free) free_pulse();
  endtask
  initial begin
    repeat (3) @(negedge wr_clk);
    chk("rst_outs", {wr_data[15:0], wr_addr, wr_en, line_done}, 0);
    wr_rst = 1'b0;
    @(negedge wr_clk);
    chk("rst_flags", {line_idx, frame_start, ovf, len_err}, 0);
    send_line(16, 16'h0500, 0, 0);
    vs_pulse();
    send_line(1024, 0, 0, 1);
    send_line(1023, 16'h1000, 0, 1);
    send_line(1030, 16'h2000, 0, 1);
    vs_pulse();
    send_line(300, 16'h3000, 1, 0);
    chk("abort_fs", n_fs, exp_fs);
    send_line(1024, 16'h4000, 0, 1);
    vs_pulse();
    for (int l = 0; l < 17; l++) send_line(64, 16'h5000 + l * 64, 0, 0);
    chk("ovf_after_17", 32'(ovf), 1);
    vs_pulse();
    repeat (20) free_pulse();
    for (int l = 0; l < 17; l++) send_line(8, 16'h6000 + l * 8, 0, 0);
    chk("ovf_saturated", 32'(ovf), 1);
    repeat (4) free_pulse();
    vs_pulse();
    begin
      bit w;
      w = cred > 0;
      if (w) cred--;
      for (int i = 0; i <= 100; i++) begin
        @(negedge wr_clk);
        de_in = 1'b1;
        pix_in = 16'(16'h7000 + i);
        if (w && i % 2 == 1)
          wq.push_back('{13'(ptr * 512 + i / 2), {16'(16'h7000 + i), 16'(16'h7000 + i - 1)}});
      end
      #2 wr_rst = 1'b1;
      #1;
      chk("arst_wr", {wr_data[15:0], wr_addr, wr_en}, 0);
      chk("arst_hi", 32'(wr_data[31:16]), 0);
      chk("arst_misc", {line_done, line_idx, frame_start, ovf, len_err}, 0);
      wq.delete(); dq.delete();
      ptr = 0; cred = 16; armed = 0; ovf_m = 0; lerr_m = 0;
      @(negedge wr_clk);
      de_in = 1'b0;
      wr_rst = 1'b0;
    end
    send_line(32, 16'h7800, 0, 0);
    send_line(32, 16'h7900, 0, 0);
    vs_pulse();
    for (int l = 0; l < 40; l++) send_line(1024, 16'h8000 + l * 37, 0, 1);
    chk("addr_wrap", 32'(wrap_seen), 1);
    chk("ovf_steady", 32'(ovf), 0);
    chk("fs_final", n_fs, exp_fs);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
